// File: rtl/fp_norm_pkg.sv
// Shared definitions for the FP post-add normalizer.
// Holds the exponent-stage opcodes, the FSM state type and the default field widths.
package fp_norm_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 24;

  // Opcodes understood by the downstream exponent increment/decrement stage
  localparam logic [3:0] ALUOP_ADD = 4'b0000;
  localparam logic [3:0] ALUOP_SUB = 4'b0011;

  // Wide enough for any practical exponent field; users slice the low EXP_W bits
  localparam logic [31:0] EXP_ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT_R = 2'd1,
    SHIFT_L = 2'd2,
    DONE    = 2'd3
  } norm_state_t;

endpackage

// File: rtl/fp_norm_shifter.sv
// Mantissa register for the normalizer.
// Holds the raw W-bit mantissa (carry bit included) and applies one
// load / clear / shift operation per clock. Clear has highest priority.
// Only the low W-1 bits leave the block; the carry bit is consumed by
// the right shift and never needs to be observed directly.
module fp_norm_shifter #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_shr,
  input  logic         i_shl,
  output logic [W-2:0] o_mant
);

  logic [W-1:0] r_mant;

  // One mantissa operation per cycle, priority clear > load > right > left
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mant <= '0;
    end else if (i_clr) begin
      r_mant <= '0;
    end else if (i_load) begin
      r_mant <= i_data;
    end else if (i_shr) begin
      r_mant <= {1'b0, r_mant[W-1:1]};
    end else if (i_shl) begin
      r_mant <= {r_mant[W-2:0], 1'b0};
    end
  end

  assign o_mant = r_mant[W-2:0];

endmodule

// File: rtl/fp_normalizer.sv
// Sequential post-add normalizer for the single-precision FP ALU.
// Shifts the raw adder mantissa one bit per cycle and steps the exponent
// through the external increment/decrement stage, registering its result.
// Optional feature macro: FP_NORM_STICKY_EN adds a sticky output that
// collects bits lost on right shifts; without it those bits are truncated.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for start; latches exp/mant and picks the path
//   SHIFT_R | one right shift on carry-out, exponent +1, overflow check
//   SHIFT_L | left shift per cycle, exponent -1, until hidden bit or exp 0
//   DONE    | done pulse for one cycle, results held, start ignored
module fp_normalizer
  import fp_norm_pkg::*;
#(
  parameter int EXP_W  = FP_EXP_W,
  parameter int MANT_W = FP_MANT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [MANT_W:0]   mant_in,
  output logic [EXP_W-1:0]  inc_dec_value,
  output logic [3:0]        inc_dec_aluop,
  output logic              inc_dec_enable,
  input  logic [EXP_W-1:0]  inc_dec_result,
  output logic              busy,
  output logic              done,
  output logic [EXP_W-1:0]  exp_out,
  output logic [MANT_W-1:0] mant_out,
  output logic              overflow,
  output logic              underflow
`ifdef FP_NORM_STICKY_EN
  ,
  output logic              sticky
`endif
);

  localparam logic [EXP_W-1:0] EXP_MAX = EXP_ALL_ONES[EXP_W-1:0];
  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

  norm_state_t       r_state;
  logic [EXP_W-1:0]  r_exp;
  logic              r_done;
  logic              r_ovf;
  logic              r_unf;

  logic              w_accept;
  logic              w_res_max;
  logic              w_exp_one;
  logic              w_clr;
  logic              w_shr;
  logic              w_shl;
  logic [MANT_W-1:0] w_mant;

  assign w_accept  = (r_state == IDLE) && start;
  assign w_res_max = (inc_dec_result == EXP_MAX);
  // At exp==1 the value is already at the denormal scale: drop to exp 0, no shift
  assign w_exp_one = (r_exp == EXP_ONE);

  // Shifting to infinity clears the mantissa instead of shifting it
  assign w_clr = (r_state == SHIFT_R) && w_res_max;
  assign w_shr = (r_state == SHIFT_R);
  assign w_shl = (r_state == SHIFT_L) && !w_exp_one;

  fp_norm_shifter #(
    .W (MANT_W + 1)
  ) u_shifter (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_clr),
    .i_load  (w_accept),
    .i_data  (mant_in),
    .i_shr   (w_shr),
    .i_shl   (w_shl),
    .o_mant  (w_mant)
  );

  // Control FSM with exponent register, done pulse and range flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_exp   <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            r_exp <= exp_in;
            if (mant_in == '0) begin
              r_exp   <= '0;
              r_state <= DONE;
              r_done  <= 1'b1;
            end else if (exp_in == EXP_MAX) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else if (mant_in[MANT_W]) begin
              r_state <= SHIFT_R;
            end else if (mant_in[MANT_W-1] || (exp_in == '0)) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= SHIFT_L;
            end
          end
        end
        SHIFT_R: begin
          r_exp   <= inc_dec_result;
          r_state <= DONE;
          r_done  <= 1'b1;
          if (w_res_max) begin
            r_ovf <= 1'b1;
          end
        end
        SHIFT_L: begin
          r_exp <= inc_dec_result;
          if (w_exp_one) begin
            r_unf   <= 1'b1;
            r_state <= DONE;
            r_done  <= 1'b1;
          end else if (w_mant[MANT_W-2]) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef FP_NORM_STICKY_EN
  logic r_sticky;

  // Collect every bit dropped off the bottom by a right shift
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sticky <= 1'b0;
    end else if (w_accept) begin
      r_sticky <= 1'b0;
    end else if (r_state == SHIFT_R) begin
      r_sticky <= r_sticky | w_mant[0];
    end
  end

  assign sticky = r_sticky;
`endif

  assign inc_dec_value  = r_exp;
  assign inc_dec_aluop  = (r_state == SHIFT_L) ? ALUOP_SUB : ALUOP_ADD;
  assign inc_dec_enable = (r_state == SHIFT_R) || (r_state == SHIFT_L);

  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign exp_out   = r_exp;
  assign mant_out  = w_mant;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed bench for fp_normalizer with a behavioural exponent stage.
// Build with FP_NORM_STICKY_EN defined to also check the sticky output.
module tb_fp_normalizer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  exp_in = '0;
  logic [24:0] mant_in = '0;
  logic [7:0]  inc_dec_value;
  logic [3:0]  inc_dec_aluop;
  logic        inc_dec_enable;
  logic [7:0]  inc_dec_result;
  logic        busy, done, overflow, underflow;
  logic [7:0]  exp_out;
  logic [23:0] mant_out;
`ifdef FP_NORM_STICKY_EN
  logic        sticky;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Exponent increment/decrement stage
  always_comb begin
    inc_dec_result = inc_dec_value;
    if (inc_dec_aluop == 4'b0000)      inc_dec_result = inc_dec_value + 8'd1;
    else if (inc_dec_aluop == 4'b0011) inc_dec_result = inc_dec_value - 8'd1;
  end

  fp_normalizer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .exp_in         (exp_in),
    .mant_in        (mant_in),
    .inc_dec_value  (inc_dec_value),
    .inc_dec_aluop  (inc_dec_aluop),
    .inc_dec_enable (inc_dec_enable),
    .inc_dec_result (inc_dec_result),
    .busy           (busy),
    .done           (done),
    .exp_out        (exp_out),
    .mant_out       (mant_out),
    .overflow       (overflow),
    .underflow      (underflow)
`ifdef FP_NORM_STICKY_EN
    ,
    .sticky         (sticky)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Start one operation and wait for done; reports latency and exp-stage activity
  task automatic run_op(input logic [7:0] e, input logic [24:0] m, output int lat,
                        output logic saw_en, output logic saw_add, output logic saw_sub);
    @(negedge clk);
    exp_in = e; mant_in = m; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; saw_en = 1'b0; saw_add = 1'b0; saw_sub = 1'b0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (inc_dec_enable) begin
        saw_en = 1'b1;
        if (inc_dec_aluop == 4'b0000) saw_add = 1'b1;
        if (inc_dec_aluop == 4'b0011) saw_sub = 1'b1;
      end
      if (done) break;
    end
    chk("done_seen", done, 1'b1);
  endtask

  typedef struct {
    string       name;
    logic [7:0]  e;
    logic [24:0] m;
    int          lat;
    logic [7:0]  x_exp;
    logic [23:0] x_mant;
    logic        x_ovf;
    logic        x_unf;
    logic        x_sticky;
    logic        x_en;
    logic        x_sub;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat;
    logic saw_en, saw_add, saw_sub, seen;

    // carry out: one right shift, exp +1
    vecs.push_back('{"rshift",  8'h80, 25'h1800000, 2, 8'h81, 24'hC00000, 0, 0, 0, 1, 0});
    // two left shifts, exp -2
    vecs.push_back('{"lshift2", 8'h80, 25'h0200000, 3, 8'h7E, 24'h800000, 0, 0, 0, 1, 1});
    // zero mantissa forces exp 0, no exp-stage use
    vecs.push_back('{"zero",    8'h55, 25'h0000000, 1, 8'h00, 24'h000000, 0, 0, 0, 0, 0});
    // right shift into all-ones exponent: infinity, lost lsb was 1
    vecs.push_back('{"ovf",     8'hFE, 25'h1000001, 2, 8'hFF, 24'h000000, 1, 0, 1, 1, 0});
    // exp 3: shifts at exp 3 and 2 (0x10->0x40), then exp 1 -> 0 without shift
    vecs.push_back('{"unf",     8'h03, 25'h0000010, 4, 8'h00, 24'h000040, 0, 1, 0, 1, 1});
    // already normalized: passes straight through
    vecs.push_back('{"norm",    8'h10, 25'h0ABCDEF, 1, 8'h10, 24'hABCDEF, 0, 0, 0, 0, 0});
    // all-ones exponent input is left untouched
    vecs.push_back('{"special", 8'hFF, 25'h0400000, 1, 8'hFF, 24'h400000, 0, 0, 0, 0, 0});
    // exp 0 with unnormalized mantissa: untouched, no underflow flag
    vecs.push_back('{"exp0",    8'h00, 25'h0012345, 1, 8'h00, 24'h012345, 0, 0, 0, 0, 0});
    // longest left normalization: 23 shifts, exp 0x80-23
    vecs.push_back('{"lmax",    8'h80, 25'h0000001, 24, 8'h69, 24'h800000, 0, 0, 0, 1, 1});
    // right shift of even mantissa: nothing lost
    vecs.push_back('{"rshift2", 8'h00, 25'h1000002, 2, 8'h01, 24'h800001, 0, 0, 0, 1, 0});

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_exp", exp_out, 0);
    chk("rst_mant", mant_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    chk("rst_en", inc_dec_enable, 0);
`ifdef FP_NORM_STICKY_EN
    chk("rst_sticky", sticky, 0);
`endif
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].e, vecs[i].m, lat, saw_en, saw_add, saw_sub);
      chk({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      chk({vecs[i].name, "_exp"}, exp_out, vecs[i].x_exp);
      chk({vecs[i].name, "_mant"}, mant_out, vecs[i].x_mant);
      chk({vecs[i].name, "_ovf"}, overflow, vecs[i].x_ovf);
      chk({vecs[i].name, "_unf"}, underflow, vecs[i].x_unf);
      chk({vecs[i].name, "_en"}, saw_en, vecs[i].x_en);
      chk({vecs[i].name, "_aluop_sub"}, saw_sub, vecs[i].x_sub);
      chk({vecs[i].name, "_aluop_add"}, saw_add, vecs[i].x_en & ~vecs[i].x_sub);
`ifdef FP_NORM_STICKY_EN
      chk({vecs[i].name, "_sticky"}, sticky, vecs[i].x_sticky);
`endif
      @(negedge clk);
      chk({vecs[i].name, "_done_pulse"}, done, 0);
      chk({vecs[i].name, "_idle"}, busy, 0);
      chk({vecs[i].name, "_hold_exp"}, exp_out, vecs[i].x_exp);
    end

    // async reset in the middle of a left normalization
    @(negedge clk);
    exp_in = 8'h80; mant_in = 25'h0200000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_en", inc_dec_enable, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_en", inc_dec_enable, 0);
    seen = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("abort_quiet", seen, 0);

    // rerun; start while busy and start during DONE are both ignored
    @(negedge clk);
    exp_in = 8'h80; mant_in = 25'h0200000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    exp_in = 8'h10; mant_in = 25'h1800000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1;
    while (lat < 40 && !done) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_start_lat", lat, 3);
    chk("busy_start_exp", exp_out, 8'h7E);
    chk("busy_start_mant", mant_out, 24'h800000);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("done_start_idle", busy, 0);
    chk("done_start_exp", exp_out, 8'h7E);
    chk("done_start_mant", mant_out, 24'h800000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
